// File: rtl/uart_pkg.sv
// Shared constants, FSM state type and parity helper for the configurable UART transmitter.
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        PAR   = 3'd3,
        STOP  = 3'd4
    } tx_state_e;

    // Callers zero-extend narrower words; the extra zero bits do not change the XOR.
    function automatic logic calc_parity(input logic [8:0] bits, input logic odd);
        return (^bits) ^ odd;
    endfunction

endpackage

// File: rtl/uart_tx_cfg_if.sv
// Write-side handshake of the UART transmitter: producer drives data, transmitter returns ready.
interface uart_tx_cfg_if #(
    parameter int DATA_BITS = 8
);
    logic                 data_valid;
    logic [DATA_BITS-1:0] data;
    logic                 data_ready;

    modport master (output data_valid, output data, input data_ready);
    modport slave  (input data_valid, input data, output data_ready);
endinterface

// File: rtl/uart_fifo.sv
// Synchronous FIFO with registered occupancy count; reads are first-word-fall-through.
module uart_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    push,
    input  logic                    pop,
    input  logic [WIDTH-1:0]        din,
    output logic [WIDTH-1:0]        dout,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    full,
    output logic                    empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push_s, do_pop_s;

    assign full      = (count_q == FULL_CNT);
    assign empty     = (count_q == '0);
    assign do_push_s = push & ~full;
    assign do_pop_s  = pop & ~empty;
    assign dout      = mem_q[rd_ptr_q];
    assign count     = count_q;

    // Pointer and occupancy next-state; pointers wrap naturally since DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push_s) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (do_pop_s) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({do_push_s, do_pop_s})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Storage array; no reset needed because pointers define validity.
    always_ff @(posedge clk) begin
        if (do_push_s && !reset) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    // Pointer and count registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: FIFO-buffered words sent as start/data/parity/stop
// frames, with the baud divisor sampled once per frame.
module uart_tx_cfg
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = PAR_NONE,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [15:0]                  baud_div,
    uart_tx_cfg_if.slave                 tx_if,
    output logic                         serial_txd,
    output logic                         busy,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_count
);
    localparam int         CW         = $clog2(FIFO_DEPTH) + 1;
    localparam logic [3:0] LAST_DATA  = 4'(DATA_BITS - 1);
    localparam logic [3:0] LAST_STOP  = 4'(STOP_BITS - 1);
    localparam logic       PAR_IS_ODD = (PARITY == PAR_ODD);

    generate
        if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
            $error("uart_tx_cfg: DATA_BITS must be in 5..9");
        end
        if (PARITY < PAR_NONE || PARITY > PAR_ODD) begin : g_bad_parity
            $error("uart_tx_cfg: PARITY must be 0, 1 or 2");
        end
        if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
            $error("uart_tx_cfg: STOP_BITS must be 1 or 2");
        end
        if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
            $error("uart_tx_cfg: FIFO_DEPTH must be a power of two, at least 2");
        end
    endgenerate

    tx_state_e            state_q, state_d;
    logic [15:0]          baud_cnt_q, baud_cnt_d;
    logic [15:0]          div_q, div_d;
    logic [3:0]           bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 par_q, par_d;
    logic                 txd_q, busy_q;

    logic                 txd_s;
    logic                 fifo_push_s, fifo_pop_s;
    logic                 fifo_full_s, fifo_empty_s;
    logic [DATA_BITS-1:0] fifo_dout_s;
    logic [CW-1:0]        fifo_count_s;
    logic [15:0]          div_eff_s;
    logic                 bit_end_s;

    assign tx_if.data_ready = ~fifo_full_s;
    assign fifo_push_s      = tx_if.data_valid & ~fifo_full_s;
    assign div_eff_s        = (baud_div == 16'd0) ? 16'd1 : baud_div;
    assign bit_end_s        = (baud_cnt_q == (div_q - 16'd1));

    uart_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push_s),
        .pop   (fifo_pop_s),
        .din   (tx_if.data),
        .dout  (fifo_dout_s),
        .count (fifo_count_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s)
    );

    // Frame sequencer: next state, counters and the line level for the current state.
    always_comb begin
        state_d    = state_q;
        baud_cnt_d = baud_cnt_q + 16'd1;
        bit_cnt_d  = bit_cnt_q;
        div_d      = div_q;
        data_d     = data_q;
        par_d      = par_q;
        fifo_pop_s = 1'b0;
        txd_s      = 1'b1;
        case (state_q)
            IDLE: begin
                txd_s      = 1'b1;
                baud_cnt_d = 16'd0;
                if (!fifo_empty_s) begin
                    fifo_pop_s = 1'b1;
                    data_d     = fifo_dout_s;
                    par_d      = calc_parity(9'(fifo_dout_s), PAR_IS_ODD);
                    div_d      = div_eff_s;
                    bit_cnt_d  = 4'd0;
                    state_d    = START;
                end else begin
                    state_d    = IDLE;
                end
            end
            START: begin
                txd_s = 1'b0;
                if (bit_end_s) begin
                    baud_cnt_d = 16'd0;
                    bit_cnt_d  = 4'd0;
                    state_d    = DATA;
                end else begin
                    state_d    = START;
                end
            end
            DATA: begin
                txd_s = data_q[0];
                if (bit_end_s) begin
                    baud_cnt_d = 16'd0;
                    data_d     = {1'b0, data_q[DATA_BITS-1:1]};
                    if (bit_cnt_q == LAST_DATA) begin
                        bit_cnt_d = 4'd0;
                        state_d   = (PARITY != PAR_NONE) ? PAR : STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end else begin
                    state_d    = DATA;
                end
            end
            PAR: begin
                txd_s = par_q;
                if (bit_end_s) begin
                    baud_cnt_d = 16'd0;
                    bit_cnt_d  = 4'd0;
                    state_d    = STOP;
                end else begin
                    state_d    = PAR;
                end
            end
            STOP: begin
                txd_s = 1'b1;
                if (bit_end_s) begin
                    baud_cnt_d = 16'd0;
                    if (bit_cnt_q != LAST_STOP) begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (!fifo_empty_s) begin
                        // Back-to-back: next frame starts with no idle bit-time.
                        fifo_pop_s = 1'b1;
                        data_d     = fifo_dout_s;
                        par_d      = calc_parity(9'(fifo_dout_s), PAR_IS_ODD);
                        div_d      = div_eff_s;
                        bit_cnt_d  = 4'd0;
                        state_d    = START;
                    end else begin
                        bit_cnt_d  = 4'd0;
                        state_d    = IDLE;
                    end
                end else begin
                    state_d    = STOP;
                end
            end
            default: begin
                baud_cnt_d = 16'd0;
                bit_cnt_d  = 4'd0;
                state_d    = IDLE;
            end
        endcase
    end

    // State and output registers; line and busy trail the state by one cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            baud_cnt_q <= 16'd0;
            bit_cnt_q  <= 4'd0;
            div_q      <= 16'd1;
            data_q     <= '0;
            par_q      <= 1'b0;
            txd_q      <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_cnt_q <= baud_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            div_q      <= div_d;
            data_q     <= data_d;
            par_q      <= par_d;
            txd_q      <= txd_s;
            busy_q     <= (state_q != IDLE);
        end
    end

    assign serial_txd = txd_q;
    assign busy       = busy_q;
    assign fifo_count = fifo_count_s;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Scoreboard bench for uart_tx_cfg: an 8N1 instance with a frame-decoding monitor
// and a 7O2 instance checked cycle by cycle against a queue of expected line levels.
module tb_uart_tx_cfg;
    import uart_pkg::*;

    typedef struct {
        logic [7:0] d;
        int         div;
    } exp_t;

    logic        clk;
    logic        rst_a, rst_b;
    logic [15:0] baud_a, baud_b;
    logic        txd_a, busy_a, txd_b, busy_b;
    logic [2:0]  cnt_a, cnt_b;

    uart_tx_cfg_if #(.DATA_BITS(8)) if_a ();
    uart_tx_cfg_if #(.DATA_BITS(7)) if_b ();

    uart_tx_cfg #(.DATA_BITS(8), .PARITY(PAR_NONE), .STOP_BITS(1), .FIFO_DEPTH(4)) dut_a (
        .clk(clk), .reset(rst_a), .baud_div(baud_a), .tx_if(if_a.slave),
        .serial_txd(txd_a), .busy(busy_a), .fifo_count(cnt_a)
    );

    uart_tx_cfg #(.DATA_BITS(7), .PARITY(PAR_ODD), .STOP_BITS(2), .FIFO_DEPTH(4)) dut_b (
        .clk(clk), .reset(rst_b), .baud_div(baud_b), .tx_if(if_b.slave),
        .serial_txd(txd_b), .busy(busy_b), .fifo_count(cnt_b)
    );

    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    bit   mon_en = 1'b0;
    int   frames_done = 0;
    exp_t sb[$];
    int   starts[$];
    logic lvl_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Frame monitor for the 8N1 instance: decodes each frame against the scoreboard.
    initial begin : mon_a
        exp_t e;
        logic bits[10];
        forever begin
            @(negedge clk);
            if (mon_en && txd_a === 1'b0) begin
                starts.push_back(cyc);
                check_eq("sb_has_entry", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                end else begin
                    e.d = 8'h00;
                    e.div = 4;
                end
                bits[0] = 1'b0;
                for (int k = 0; k < 8; k++) bits[k+1] = e.d[k];
                bits[9] = 1'b1;
                for (int k = 0; k < 10; k++) begin
                    for (int c = 0; c < e.div; c++) begin
                        if (k != 0 || c != 0) @(negedge clk);
                        check_eq("frame_bit", 32'(txd_a), 32'(bits[k]));
                        check_eq("busy_in_frame", 32'(busy_a), 32'd1);
                    end
                end
                frames_done++;
            end
        end
    end

    task automatic push_a(input logic [7:0] d, input int div, input bit to_sb,
                          output int edge_n, output int waited,
                          output logic first_rdy, output logic [2:0] first_cnt);
        exp_t e;
        waited = 0;
        @(negedge clk);
        if_a.data_valid = 1'b1;
        if_a.data = d;
        first_rdy = if_a.data_ready;
        first_cnt = cnt_a;
        while (if_a.data_ready !== 1'b1 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 200) check_eq("push_timeout", 32'(waited), 32'd0);
        edge_n = cyc + 1;
        if (to_sb) begin
            e.d = d;
            e.div = div;
            sb.push_back(e);
        end
    endtask

    task automatic idle_a();
        @(negedge clk);
        if_a.data_valid = 1'b0;
    endtask

    task automatic wait_frames(input int target, input int budget);
        int k = 0;
        while (frames_done < target && k < budget) begin
            @(negedge clk);
            k++;
        end
        check_eq("frames_done", 32'(frames_done), 32'(target));
    endtask

    task automatic count_busy(input int window, output int n);
        n = 0;
        repeat (window) begin
            @(negedge clk);
            if (busy_a === 1'b1) n++;
        end
    endtask

    initial begin : main
        int   e[6];
        int   wt[6];
        logic fr[6];
        logic [2:0] fc[6];
        logic [7:0] words[6];
        int   s0, f0, n0, bc, lows, k;
        logic [6:0] db;
        logic bbits[11];

        words[0] = 8'h3C; words[1] = 8'hC3; words[2] = 8'h00;
        words[3] = 8'hFF; words[4] = 8'h5A; words[5] = 8'h96;

        rst_a = 1'b1; rst_b = 1'b1;
        baud_a = 16'd4; baud_b = 16'd2;
        if_a.data_valid = 1'b0; if_a.data = 8'h00;
        if_b.data_valid = 1'b0; if_b.data = 7'h00;
        repeat (3) @(negedge clk);
        check_eq("rst_txd", 32'(txd_a), 32'd1);
        check_eq("rst_busy", 32'(busy_a), 32'd0);
        check_eq("rst_count", 32'(cnt_a), 32'd0);
        check_eq("rst_ready", 32'(if_a.data_ready), 32'd1);
        check_eq("rst_txd_b", 32'(txd_b), 32'd1);
        rst_a = 1'b0; rst_b = 1'b0;
        mon_en = 1'b1;

        // 8N1, baud 4, single word 0xA5
        s0 = starts.size(); f0 = frames_done;
        push_a(8'hA5, 4, 1'b1, n0, wt[0], fr[0], fc[0]);
        idle_a();
        count_busy(60, bc);
        check_eq("busy_cycles_8n1", 32'(bc), 32'd40);
        check_eq("frames_8n1", 32'(frames_done), 32'(f0 + 1));
        check_eq("start_edge_8n1", 32'(starts[s0]), 32'(n0 + 2));
        check_eq("idle_txd", 32'(txd_a), 32'd1);
        check_eq("idle_busy", 32'(busy_a), 32'd0);

        // FIFO fill with six continuous pushes, back-to-back frames
        s0 = starts.size(); f0 = frames_done;
        for (int i = 0; i < 6; i++) push_a(words[i], 4, 1'b1, e[i], wt[i], fr[i], fc[i]);
        idle_a();
        check_eq("push_pop_same_edge_count", 32'(fc[2]), 32'd1);
        check_eq("full_ready_low", 32'(fr[5]), 32'd0);
        check_eq("full_count", 32'(fc[5]), 32'd4);
        check_eq("full_accept_edge", 32'(e[5] - e[0]), 32'd42);
        wait_frames(f0 + 6, 400);
        check_eq("first_start_edge", 32'(starts[s0] - e[0]), 32'd2);
        for (int i = 1; i < 6; i++)
            check_eq("contiguous_frames", 32'(starts[s0+i] - starts[s0+i-1]), 32'd40);

        // baud_div = 0 behaves as 1
        repeat (5) @(negedge clk);
        baud_a = 16'd0;
        f0 = frames_done;
        push_a(8'h6D, 1, 1'b1, n0, wt[0], fr[0], fc[0]);
        idle_a();
        count_busy(20, bc);
        check_eq("busy_cycles_div0", 32'(bc), 32'd10);
        check_eq("frames_div0", 32'(frames_done), 32'(f0 + 1));

        // divisor change mid-frame applies only to the next frame
        baud_a = 16'd4;
        s0 = starts.size(); f0 = frames_done;
        push_a(8'h5A, 4, 1'b1, e[0], wt[0], fr[0], fc[0]);
        push_a(8'hC3, 8, 1'b1, e[1], wt[1], fr[1], fc[1]);
        idle_a();
        repeat (10) @(negedge clk);
        baud_a = 16'd8;
        wait_frames(f0 + 2, 300);
        check_eq("div_change_gap", 32'(starts[s0+1] - starts[s0]), 32'd40);
        repeat (3) @(negedge clk);
        check_eq("div_change_idle", 32'(busy_a), 32'd0);

        // reset during data bit 3 with two words queued
        baud_a = 16'd4;
        mon_en = 1'b0;
        push_a(8'hF0, 4, 1'b0, n0, wt[0], fr[0], fc[0]);
        push_a(8'h55, 4, 1'b0, e[1], wt[1], fr[1], fc[1]);
        push_a(8'hAA, 4, 1'b0, e[2], wt[2], fr[2], fc[2]);
        idle_a();
        while (cyc < n0 + 19) @(negedge clk);
        check_eq("queued_before_rst", 32'(cnt_a), 32'd2);
        check_eq("bit3_before_rst", 32'(txd_a), 32'd0);
        rst_a = 1'b1;
        if_a.data_valid = 1'b1;
        if_a.data = 8'hEE;
        @(negedge clk);
        check_eq("rst_mid_txd", 32'(txd_a), 32'd1);
        check_eq("rst_mid_busy", 32'(busy_a), 32'd0);
        check_eq("rst_mid_count", 32'(cnt_a), 32'd0);
        @(negedge clk);
        check_eq("valid_during_rst", 32'(cnt_a), 32'd0);
        if_a.data_valid = 1'b0;
        rst_a = 1'b0;
        lows = 0;
        repeat (80) begin
            @(negedge clk);
            if (txd_a !== 1'b1 || busy_a !== 1'b0) lows++;
        end
        check_eq("no_frame_after_rst", 32'(lows), 32'd0);
        mon_en = 1'b1;
        f0 = frames_done;
        push_a(8'h81, 4, 1'b1, n0, wt[0], fr[0], fc[0]);
        idle_a();
        wait_frames(f0 + 1, 100);

        // 7 data bits, odd parity, two stop bits, baud 2
        db = 7'h03;
        bbits[0] = 1'b0;
        for (int i = 0; i < 7; i++) bbits[i+1] = db[i];
        bbits[8] = ~(^db);
        bbits[9] = 1'b1;
        bbits[10] = 1'b1;
        @(negedge clk);
        if_b.data_valid = 1'b1;
        if_b.data = db;
        n0 = cyc + 1;
        for (int i = 0; i < 11; i++) begin
            lvl_q.push_back(bbits[i]);
            lvl_q.push_back(bbits[i]);
        end
        @(negedge clk);
        if_b.data_valid = 1'b0;
        k = 0;
        while (txd_b !== 1'b0 && k < 10) begin
            @(negedge clk);
            k++;
        end
        check_eq("b_start_edge", 32'(cyc), 32'(n0 + 2));
        k = 0;
        while (lvl_q.size() != 0) begin
            if (k != 0) @(negedge clk);
            check_eq("b_level", 32'(txd_b), 32'(lvl_q.pop_front()));
            check_eq("b_busy", 32'(busy_b), 32'd1);
            k++;
        end
        @(negedge clk);
        check_eq("b_frame_end_busy", 32'(busy_b), 32'd0);
        check_eq("b_frame_end_txd", 32'(txd_b), 32'd1);

        check_eq("sb_drained", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_cfg.md
UART_TX_CFG -- requirements
Module: uart_tx_cfg

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8, data bits per frame (legal 5..9).
REQ-002 SHALL have parameter PARITY, default 0, parity mode: 0 none, 1 even, 2 odd.
REQ-003 SHALL have parameter STOP_BITS, default 1, stop bits per frame (legal 1..2).
REQ-004 SHALL have parameter FIFO_DEPTH, default 4, entries in the transmit FIFO (power of 2, >=2).
REQ-005 SHALL have port clk  input  1  system clock; all logic on the rising edge.
REQ-006 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-007 SHALL have port baud_div  input  16  clk cycles per serial bit; 0 is treated as 1.
REQ-008 SHALL have port data_valid  input  1  write strobe for data.
REQ-009 SHALL have port data  input  DATA_BITS  byte to send, LSB first.
REQ-010 SHALL have port data_ready  output  1  FIFO not full.
REQ-011 SHALL have port serial_txd  output  1  serial line, registered, idle high.
REQ-012 SHALL have port busy  output  1  frame in progress.
REQ-013 SHALL have port fifo_count  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Function
REQ-014 SHALL accept data into the FIFO on any edge where data_valid && data_ready; data_valid while data_ready is low SHALL be ignored with no state change.
REQ-015 SHALL drive data_ready = (fifo_count != FIFO_DEPTH), combinationally from registered state.
REQ-016 SHALL, on a same-cycle push and pop, leave fifo_count unchanged and preserve FIFO order.
REQ-017 SHALL implement FSM states IDLE, START, DATA, PAR, STOP.
REQ-018 SHALL, in IDLE with fifo_count != 0, pop one entry, latch it and latch baud_div, and enter START.
REQ-019 SHALL, for a word accepted at edge N into an empty FIFO with the FSM in IDLE, drive serial_txd low starting at edge N+2.
REQ-020 SHALL hold every bit for exactly max(baud_div,1) clk cycles, using the divisor latched at frame start; baud_div changes mid-frame SHALL NOT affect the current frame.
REQ-021 SHALL sequence START(0) -> DATA bits 0..DATA_BITS-1 -> PAR (only if PARITY!=0) -> STOP (STOP_BITS bit-times of 1).
REQ-022 SHALL produce a parity bit equal to XOR of the data bits for even parity and its inverse for odd parity.
REQ-023 SHALL, at the end of STOP with FIFO non-empty, pop the next entry and begin START on the next cycle, with no idle bit-time between frames.
REQ-024 SHALL, at the end of STOP with FIFO empty, return to IDLE with serial_txd high.
REQ-025 SHALL assert busy in every state except IDLE.
REQ-026 SHALL produce a frame length of (1+DATA_BITS+(PARITY!=0)+STOP_BITS)*max(baud_div,1) cycles.

Reset
REQ-027 SHALL, while reset is high, drive serial_txd=1, busy=0 and fifo_count=0, put the FSM in IDLE, and clear the bit and baud counters.
REQ-028 SHALL, on reset asserted mid-frame, abort the frame, drive serial_txd high on the next edge, and discard all FIFO contents.
REQ-029 SHALL ignore data_valid during reset.

Structure
REQ-030 SHALL take parity-mode constants (PAR_NONE, PAR_EVEN, PAR_ODD) and the FSM state typedef from shared package uart_pkg.
REQ-031 SHALL instantiate the FIFO as sub-module uart_fifo, a synchronous FIFO parameterised on WIDTH and DEPTH with push/pop/count ports.
REQ-032 SHALL flag illegal parameter values at elaboration.

Verification
REQ-033 SHALL verify the 8N1 default: baud_div=4, push 0xA5 -> serial_txd is 0,1,0,1,0,0,1,0,1,1, each level held 4 cycles, start bit at edge N+2, busy high for 40 cycles.
REQ-034 SHALL verify parity and two stop bits: DATA_BITS=7, PARITY=2, STOP_BITS=2, baud_div=2, push 0x03 -> 7 data bits, parity bit 1, two stop bits, frame of 22 cycles.
REQ-035 SHALL verify FIFO full/back-to-back: FIFO_DEPTH=4, push 6 words continuously -> data_ready low once fifo_count=4, no word lost or reordered, frames contiguous with no idle gap.
REQ-036 SHALL verify baud_div corner cases: baud_div=0 -> bits 1 cycle each; baud_div 4->8 changed mid-frame -> current frame stays at 4, next frame at 8.
REQ-037 SHALL verify reset mid-frame: reset during bit 3 with 2 words queued -> serial_txd=1 and busy=0 next cycle, fifo_count=0, no further frames until a new push.
REQ-038 SHALL verify simultaneous push and pop: push on the pop edge at fifo_count=1 -> fifo_count stays 1 and the pushed word is sent in the next frame.
